ret_stack: RTL and testbench

Hardware return-address stack for the jrb8 CPU, the counterpart of the jump unit. The jump unit reads a 16-bit target from the 8-bit databus, high byte then low byte, and drives it onto the program counter. This block does the reverse: it captures the PC on CALL and returns it as a PC load on RET. It also provides byte-serial access so software can read the top return address onto the databus (high byte first), or write one in (high byte first).

---
 rtl/ret_stack.sv | 201 ++++++++++++++++++++
 tb/tb_ret_stack.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ret_stack.sv
`default_nettype none
// ============================================================================
// Module   : ret_stack
// Purpose  : Hardware return-address stack. Captures the PC on CALL and
//            hands it back as a one-cycle PC load on RET. Also offers
//            byte-serial read (rd) and write (wr) of the top entry over the
//            8-bit databus, high byte first.
// Revision : 1.0 - initial release
// ============================================================================
module ret_stack #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          call,
    input  logic          ret,
    input  logic          rd,
    input  logic          wr,
    input  logic [15:0]   pcin,
    input  logic [7:0]    databus,
    output logic [15:0]   pcout,
    output logic          pcoe,
    output logic [7:0]    dataout,
    output logic          dataoe,
    output logic          busy,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          ovf,
    output logic          unf
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RHI  = 2'd1;
    localparam logic [1:0] S_RLO  = 2'd2;
    localparam logic [1:0] S_WLO  = 2'd3;

    logic [1:0]    state_q,   state_d;
    logic [CW-1:0] count_q,   count_d;
    logic [15:0]   pcout_q,   pcout_d;
    logic          pcoe_q,    pcoe_d;
    logic [7:0]    dataout_q, dataout_d;
    logic          dataoe_q,  dataoe_d;
    logic          ovf_q,     ovf_d;
    logic          unf_q,     unf_d;
    logic [7:0]    whi_q,     whi_d;     // high byte collected by wr
    logic [7:0]    rdlo_q,    rdlo_d;    // low byte held for the second rd beat

    logic [15:0]   mem_q [DEPTH];

    logic          full_w;
    logic          empty_w;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] tos_idx;
    logic [15:0]   tos_w;
    logic          push_req;
    logic          push_en;
    logic [15:0]   push_data;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);
    // Only used when not full, so count fits in the index width.
    assign wr_idx  = count_q[AW-1:0];
    // Wraps to the last slot when empty; the value is never used then.
    assign tos_idx = AW'(count_q - CW'(1));
    assign tos_w   = mem_q[tos_idx];

    // State register plus all registered outputs and holding bytes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            pcout_q   <= '0;
            pcoe_q    <= 1'b0;
            dataout_q <= '0;
            dataoe_q  <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            whi_q     <= '0;
            rdlo_q    <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pcout_q   <= pcout_d;
            pcoe_q    <= pcoe_d;
            dataout_q <= dataout_d;
            dataoe_q  <= dataoe_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            whi_q     <= whi_d;
            rdlo_q    <= rdlo_d;
        end
    end

    // Entry storage; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (reset && push_en) begin
            mem_q[wr_idx] <= push_data;
        end
    end

    // Next-state: commands only in IDLE, priority call > ret > rd > wr.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (call || ret) begin
                    state_d = S_IDLE;
                end else if (rd) begin
                    state_d = empty_w ? S_IDLE : S_RHI;
                end else if (wr) begin
                    state_d = S_WLO;
                end
            end
            S_RHI:   state_d = S_RLO;
            S_RLO:   state_d = S_IDLE;
            S_WLO:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and next values of the registered outputs.
    always_comb begin
        count_d   = count_q;
        pcout_d   = '0;
        pcoe_d    = 1'b0;
        dataout_d = '0;
        dataoe_d  = 1'b0;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        whi_d     = whi_q;
        rdlo_d    = rdlo_q;
        push_req  = 1'b0;
        push_en   = 1'b0;
        push_data = pcin;

        case (state_q)
            S_IDLE: begin
                if (call) begin
                    push_req = 1'b1;
                end else if (ret) begin
                    if (empty_w) begin
                        unf_d = 1'b1;
                    end else begin
                        count_d = count_q - CW'(1);
                        pcout_d = tos_w;
                        pcoe_d  = 1'b1;
                    end
                end else if (rd) begin
                    if (empty_w) begin
                        unf_d = 1'b1;
                    end else begin
                        dataout_d = tos_w[15:8];
                        dataoe_d  = 1'b1;
                        rdlo_d    = tos_w[7:0];
                    end
                end else if (wr) begin
                    whi_d = databus;
                end
            end
            S_RHI: begin
                dataout_d = rdlo_q;
                dataoe_d  = 1'b1;
            end
            S_WLO: begin
                push_req  = 1'b1;
                push_data = {whi_q, databus};
            end
            default: ;
        endcase

        // A push from either call or wr saturates at DEPTH.
        if (push_req) begin
            if (full_w) begin
                ovf_d = 1'b1;
            end else begin
                push_en = 1'b1;
                count_d = count_q + CW'(1);
            end
        end
    end

    // Output drive straight from registers.
    always_comb begin
        pcout   = pcout_q;
        pcoe    = pcoe_q;
        dataout = dataout_q;
        dataoe  = dataoe_q;
        busy    = (state_q != S_IDLE);
        empty   = empty_w;
        full    = full_w;
        count   = count_q;
        ovf     = ovf_q;
        unf     = unf_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ret_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_ret_stack
// Purpose  : Self-checking bench for ret_stack: directed vector table,
//            fill/overflow/underflow sequence and a randomized run against
//            a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ret_stack;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset, call, ret, rd, wr;
    logic [15:0]   pcin;
    logic [7:0]    databus;
    logic [15:0]   pcout;
    logic          pcoe;
    logic [7:0]    dataout;
    logic          dataoe, busy, empty, full;
    logic [CW-1:0] count;
    logic          ovf, unf;

    int checks = 0;
    int errors = 0;

    ret_stack #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .call(call), .ret(ret), .rd(rd), .wr(wr),
        .pcin(pcin), .databus(databus), .pcout(pcout), .pcoe(pcoe),
        .dataout(dataout), .dataoe(dataoe), .busy(busy), .empty(empty),
        .full(full), .count(count), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, c, r, rdv, w;
        logic [15:0] pc;
        logic [7:0]  db;
        logic [15:0] e_pcout;
        logic        e_pcoe;
        logic [7:0]  e_dout;
        logic        e_doe, e_busy;
        logic [3:0]  e_cnt;
        logic        e_ovf, e_unf;
    } vec_t;

    vec_t vecs[23];

    task automatic drive(input logic rs, input logic c, input logic r,
                         input logic d, input logic w,
                         input logic [15:0] pc, input logic [7:0] db);
        reset = rs; call = c; ret = r; rd = d; wr = w; pcin = pc; databus = db;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] e_pcout,
                       input logic e_pcoe, input logic [7:0] e_dout,
                       input logic e_doe, input logic e_busy,
                       input int e_cnt, input logic e_ovf, input logic e_unf);
        logic [34:0] exp_v, act_v;
        exp_v = {e_pcout, e_pcoe, e_dout, e_doe, e_busy, (e_cnt == 0),
                 (e_cnt == DEPTH), 4'(e_cnt), e_ovf, e_unf};
        act_v = {pcout, pcoe, dataout, dataoe, busy, empty, full,
                 4'(count), ovf, unf};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got pcout=%h pcoe=%b dout=%h doe=%b busy=%b empty=%b full=%b cnt=%0d ovf=%b unf=%b ; expected pcout=%h pcoe=%b dout=%h doe=%b busy=%b cnt=%0d ovf=%b unf=%b",
                     name, pcout, pcoe, dataout, dataoe, busy, empty, full, count, ovf, unf,
                     e_pcout, e_pcoe, e_dout, e_doe, e_busy, e_cnt, e_ovf, e_unf);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of return addresses plus sequence tracking
    // ------------------------------------------------------------------
    logic [15:0] m_q[$];
    logic        m_ovf, m_unf;
    int          m_rd_stage;       // 0 none, 1 high byte shown, 2 low byte shown
    logic [15:0] m_rd_val;
    logic        m_wr_pend;
    logic [7:0]  m_wr_hi;
    logic [15:0] m_pcout;
    logic        m_pcoe;
    logic [7:0]  m_dout;
    logic        m_doe;

    task automatic m_push(input logic [15:0] v);
        if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(v);
    endtask

    task automatic model_edge(input logic rs, input logic c, input logic r,
                              input logic d, input logic w,
                              input logic [15:0] pc, input logic [7:0] db);
        m_pcout = '0; m_pcoe = 1'b0; m_dout = '0; m_doe = 1'b0;
        if (!rs) begin
            m_q.delete();
            m_ovf = 0; m_unf = 0; m_rd_stage = 0; m_wr_pend = 0;
        end else if (m_wr_pend) begin
            m_push({m_wr_hi, db});
            m_wr_pend = 0;
        end else if (m_rd_stage == 1) begin
            m_dout = m_rd_val[7:0]; m_doe = 1'b1; m_rd_stage = 2;
        end else if (m_rd_stage == 2) begin
            m_rd_stage = 0;
        end else if (c) begin
            m_push(pc);
        end else if (r) begin
            if (m_q.size() == 0) m_unf = 1'b1;
            else begin
                m_pcout = m_q.pop_back(); m_pcoe = 1'b1;
            end
        end else if (d) begin
            if (m_q.size() == 0) m_unf = 1'b1;
            else begin
                m_rd_val = m_q[$]; m_dout = m_rd_val[15:8]; m_doe = 1'b1;
                m_rd_stage = 1;
            end
        end else if (w) begin
            m_wr_hi = db; m_wr_pend = 1'b1;
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 16'h0, 8'h0);

        //            rst c r d w  pcin      db     pcout    oe dout  doe bsy cnt ovf unf
        vecs[0]  = '{0, 0,0,0,0, 16'h0000, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 1,0,0,0, 16'h1234, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 1, 0, 0};
        vecs[2]  = '{1, 1,0,0,0, 16'hABCD, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 2, 0, 0};
        vecs[3]  = '{1, 0,1,0,0, 16'h0000, 8'h00, 16'hABCD, 1, 8'h00, 0, 0, 1, 0, 0};
        vecs[4]  = '{1, 0,1,0,0, 16'h0000, 8'h00, 16'h1234, 1, 8'h00, 0, 0, 0, 0, 0};
        vecs[5]  = '{1, 0,0,0,0, 16'h0000, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0};
        vecs[6]  = '{1, 1,0,0,0, 16'hBEEF, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 1, 0, 0};
        vecs[7]  = '{1, 0,0,1,0, 16'h0000, 8'h00, 16'h0000, 0, 8'hBE, 1, 1, 1, 0, 0};
        vecs[8]  = '{1, 1,0,0,0, 16'h1111, 8'h00, 16'h0000, 0, 8'hEF, 1, 1, 1, 0, 0};
        vecs[9]  = '{1, 0,0,0,0, 16'h0000, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 1, 0, 0};
        vecs[10] = '{1, 0,0,0,1, 16'h0000, 8'h5A, 16'h0000, 0, 8'h00, 0, 1, 1, 0, 0};
        vecs[11] = '{1, 0,0,0,0, 16'h0000, 8'hC3, 16'h0000, 0, 8'h00, 0, 0, 2, 0, 0};
        vecs[12] = '{1, 0,1,0,0, 16'h0000, 8'h00, 16'h5AC3, 1, 8'h00, 0, 0, 1, 0, 0};
        vecs[13] = '{1, 0,1,0,0, 16'h0000, 8'h00, 16'hBEEF, 1, 8'h00, 0, 0, 0, 0, 0};
        vecs[14] = '{1, 1,0,0,0, 16'h0042, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 1, 0, 0};
        vecs[15] = '{1, 1,1,0,0, 16'h0077, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 2, 0, 0};
        vecs[16] = '{1, 0,1,0,0, 16'h0000, 8'h00, 16'h0077, 1, 8'h00, 0, 0, 1, 0, 0};
        vecs[17] = '{1, 0,1,0,0, 16'h0000, 8'h00, 16'h0042, 1, 8'h00, 0, 0, 0, 0, 0};
        vecs[18] = '{1, 0,0,0,1, 16'h0000, 8'hFF, 16'h0000, 0, 8'h00, 0, 1, 0, 0, 0};
        vecs[19] = '{0, 0,0,0,0, 16'h0000, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0};
        vecs[20] = '{1, 0,1,0,0, 16'h0000, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 1};
        vecs[21] = '{1, 0,0,0,0, 16'h0000, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 1};
        vecs[22] = '{0, 0,0,0,0, 16'h0000, 8'h00, 16'h0000, 0, 8'h00, 0, 0, 0, 0, 0};

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].rst_n, vecs[i].c, vecs[i].r, vecs[i].rdv, vecs[i].w,
                  vecs[i].pc, vecs[i].db);
            step();
            chk($sformatf("vec%0d", i), vecs[i].e_pcout, vecs[i].e_pcoe,
                vecs[i].e_dout, vecs[i].e_doe, vecs[i].e_busy,
                int'(vecs[i].e_cnt), vecs[i].e_ovf, vecs[i].e_unf);
        end

        // Fill past capacity, then drain past empty.
        for (int i = 0; i < 9; i++) begin
            drive(1, 1, 0, 0, 0, 16'h0100 + 16'(i), 8'h00);
            step();
            chk($sformatf("fill%0d", i), 16'h0, 0, 8'h0, 0, 0,
                (i < DEPTH) ? i + 1 : DEPTH, (i == DEPTH), 0);
        end
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 1, 0, 0, 16'h0000, 8'h00);
            step();
            if (i < DEPTH)
                chk($sformatf("drain%0d", i), 16'h0107 - 16'(i), 1, 8'h0, 0, 0,
                    DEPTH - 1 - i, 1, 0);
            else
                chk("drain_unf", 16'h0, 0, 8'h0, 0, 0, 0, 1, 1);
        end

        // Randomized run against the reference model.
        drive(0, 0, 0, 0, 0, 16'h0, 8'h0);
        step();
        model_edge(0, 0, 0, 0, 0, 16'h0, 8'h0);
        chk("rand_reset", m_pcout, m_pcoe, m_dout, m_doe, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic rs, c, r, d, w;
            logic [15:0] pc;
            logic [7:0] db;
            rs = ($urandom_range(0, 99) >= 2);
            c  = ($urandom_range(0, 99) < 30);
            r  = ($urandom_range(0, 99) < 30);
            d  = ($urandom_range(0, 99) < 15);
            w  = ($urandom_range(0, 99) < 15);
            pc = 16'($urandom);
            db = 8'($urandom);
            drive(rs, c, r, d, w, pc, db);
            step();
            model_edge(rs, c, r, d, w, pc, db);
            chk($sformatf("rand%0d", n), m_pcout, m_pcoe, m_dout, m_doe,
                (m_rd_stage != 0) || m_wr_pend, m_q.size(), m_ovf, m_unf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
